direction_input: RTL

- Converts four raw push-button pins into single, debounced move commands for the 2048 game core.
- Produces the 2-bit direction code consumed by the game core (00 top, 01 bottom, 10 left, 11 right), with a valid/ready handshake and a one-hot mirror.
- Sits between the board pins and the game core. Guarantees exactly one command per physical press.

---
 rtl/game2048_pkg.sv | 30 +++
 rtl/button_debouncer.sv | 50 +++++
 rtl/direction_input.sv | 101 ++++++++++
 3 files changed

// File: rtl/game2048_pkg.sv
// Shared types for the 2048 game: move directions, game state and the input FSM state.
package game2048_pkg;

    localparam int unsigned NUM_BTN = 4;

    typedef enum logic [1:0] {
        DIR_TOP    = 2'b00,
        DIR_BOTTOM = 2'b01,
        DIR_LEFT   = 2'b10,
        DIR_RIGHT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        NOT_PLAYING = 2'b00,
        PLAYING     = 2'b01,
        WIN         = 2'b10,
        LOSE        = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        ISSUE        = 2'b01,
        WAIT_RELEASE = 2'b10
    } in_state_t;

    function automatic logic [NUM_BTN-1:0] dir_onehot(input dir_t d);
        return NUM_BTN'(1) << d;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-FF synchronizer, stability counter and one-cycle press pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // The counter only runs while the synchronized level disagrees; it clears instead of wrapping.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable = stable_q;
    assign press  = stable_q & ~stable_dly_q;

endmodule

// File: rtl/direction_input.sv
// Turns four raw buttons into one debounced move command per press, with valid/ready handshake.
module direction_input
    import game2048_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       accept_en,
    input  logic       dir_ready,
    output logic       dir_valid,
    output logic [1:0] dir_code,
    output logic [3:0] direction
);

    logic [NUM_BTN-1:0] raw, stable, press;
    dir_t               sel;
    in_state_t          state_q, state_d;
    logic               valid_q, valid_d;
    logic [1:0]         code_q, code_d;
    logic [3:0]         dir_q, dir_d;

    assign raw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[i]),
            .stable(stable[i]),
            .press (press[i])
        );
    end

    // Simultaneous presses resolve top > bottom > left > right.
    always_comb begin
        sel = DIR_RIGHT;
        if (press[2]) sel = DIR_LEFT;
        if (press[1]) sel = DIR_BOTTOM;
        if (press[0]) sel = DIR_TOP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            code_q  <= 2'b00;
            dir_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (accept_en && (press != '0)) begin
                    valid_d = 1'b1;
                    code_d  = sel;
                    dir_d   = dir_onehot(sel);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if ((valid_q && dir_ready) || !accept_en) begin
                    valid_d = 1'b0;
                    dir_d   = 4'b0000;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (stable == '0) state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                dir_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    assign dir_valid = valid_q;
    assign dir_code  = code_q;
    assign direction = dir_q;

endmodule
